fdma_wr_arb_mc: RTL and testbench

Multi-channel successor to the single-channel FDMA write controller. It arbitrates CH_NUM independent `ui_clk`-domain source FIFOs onto one FDMA write port and issues fixed-length bursts only when a whole burst is buffered. Each channel owns a ring of FDMA_BUF_SIZE DDR frame buffers, and the block raises a per-channel interrupt carrying the index of each completed buffer. It sits between the per-channel capture FIFOs and the FDMA/AXI4 write master.

---
 rtl/fdma_wr_arb_mc.sv | 172 +++++++++++++++++
 tb/tb_fdma_wr_arb_mc.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdma_wr_arb_mc.sv
// Round-robin arbiter that drains CH_NUM source FIFOs onto one FDMA write port in whole
// bursts, walking each channel through a ring of DDR frame buffers with per-buffer interrupts.
module fdma_wr_arb_mc #(
  parameter logic [31:0] ADDR_OFFSET    = 32'd0,
  parameter int unsigned CH_NUM         = 2,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned AXI_BURST_LEN  = 8,
  parameter int unsigned FDMA_BUF_SIZE  = 3,
  parameter int unsigned BUF_BYTES      = 4096,
  parameter int unsigned CNT_W          = 11
) (
  input  logic                         ui_clk,
  input  logic                         ui_rstn,
  input  logic [CH_NUM-1:0]            ch_en,
  input  logic [CH_NUM*CNT_W-1:0]      ch_rcnt,
  input  logic [CH_NUM*AXI_DATA_WIDTH-1:0] ch_data,
  output logic [CH_NUM-1:0]            ch_rden,
  output logic                         pkg_wr_areq,
  input  logic                         pkg_wr_en,
  input  logic                         pkg_wr_last,
  output logic [31:0]                  pkg_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0]    pkg_wr_data,
  output logic [31:0]                  pkg_wr_size,
  output logic [CH_NUM-1:0]            irq_req,
  output logic [CH_NUM*4-1:0]          irq_buf,
  output logic                         busy
);

  localparam int unsigned BurstBytes   = AXI_BURST_LEN * AXI_DATA_WIDTH / 8;
  localparam int unsigned BurstsPerBuf = BUF_BYTES / BurstBytes;
  localparam int unsigned GW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned BW = (BurstsPerBuf > 1) ? $clog2(BurstsPerBuf) : 1;

  typedef enum logic [1:0] {StIdle, StArb, StReq, StXfer} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [BW-1:0]       bcnt_q [CH_NUM];
  logic [BW-1:0]       bcnt_d [CH_NUM];
  logic [3:0]          bidx_q [CH_NUM];
  logic [3:0]          bidx_d [CH_NUM];
  logic [31:0]         addr_q, addr_d;
  logic [CH_NUM-1:0]   irq_req_q, irq_req_d;
  logic [CH_NUM*4-1:0] irq_buf_q, irq_buf_d;

  logic [CH_NUM-1:0]   elig;
  logic                found;
  logic [GW-1:0]       pick, cand;
  logic [BW-1:0]       pick_bcnt;
  logic [3:0]          pick_bidx;
  logic                xfer_done;

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      elig[i] = ch_en[i] && (ch_rcnt[i*CNT_W +: CNT_W] >= CNT_W'(AXI_BURST_LEN));
    end
  end

  // Search starts one past the previous grant so every channel gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    cand  = grant_q;
    for (int unsigned k = 1; k <= CH_NUM; k++) begin
      cand = GW'((32'(grant_q) + k) % CH_NUM);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    pick_bcnt = '0;
    pick_bidx = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (pick == GW'(i)) begin
        pick_bcnt = bcnt_q[i];
        pick_bidx = bidx_q[i];
      end
    end
  end

  assign xfer_done = (state_q == StXfer) && pkg_wr_last;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: state_d = StArb;
      StArb: begin
        if (found) begin
          grant_d = pick;
          addr_d  = ADDR_OFFSET + 32'(pick) * 32'(FDMA_BUF_SIZE * BUF_BYTES)
                  + 32'(pick_bidx) * 32'(BUF_BYTES) + 32'(pick_bcnt) * 32'(BurstBytes);
          state_d = StReq;
        end
      end
      StReq:  state_d = StXfer;
      StXfer: if (pkg_wr_last) state_d = StArb;
      default: state_d = StIdle;
    endcase
  end

  // A channel with a committed burst keeps its counters until that burst retires.
  always_comb begin
    irq_req_d = '0;
    irq_buf_d = irq_buf_q;
    for (int i = 0; i < CH_NUM; i++) begin
      bcnt_d[i] = bcnt_q[i];
      bidx_d[i] = bidx_q[i];
      if (!ch_en[i] && !((state_q == StReq || state_q == StXfer) && grant_q == GW'(i))) begin
        bcnt_d[i] = '0;
        bidx_d[i] = '0;
      end
      if (xfer_done && grant_q == GW'(i)) begin
        if (bcnt_q[i] < BW'(BurstsPerBuf - 1)) begin
          bcnt_d[i] = bcnt_q[i] + 1'b1;
        end else begin
          bcnt_d[i]          = '0;
          irq_buf_d[i*4 +: 4] = bidx_q[i];
          irq_req_d[i]       = 1'b1;
          bidx_d[i]          = (bidx_q[i] == 4'(FDMA_BUF_SIZE - 1)) ? 4'd0 : bidx_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state_q   <= StIdle;
      grant_q   <= GW'(CH_NUM - 1);
      addr_q    <= '0;
      irq_req_q <= '0;
      irq_buf_q <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        bcnt_q[i] <= '0;
        bidx_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      irq_req_q <= irq_req_d;
      irq_buf_q <= irq_buf_d;
      for (int i = 0; i < CH_NUM; i++) begin
        bcnt_q[i] <= bcnt_d[i];
        bidx_q[i] <= bidx_d[i];
      end
    end
  end

  always_comb begin
    ch_rden     = '0;
    pkg_wr_data = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (state_q == StXfer && grant_q == GW'(i)) begin
        ch_rden[i]  = pkg_wr_en;
        pkg_wr_data = ch_data[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
    end
  end

  assign pkg_wr_areq = (state_q == StReq);
  assign pkg_wr_addr = addr_q;
  assign pkg_wr_size = 32'(AXI_BURST_LEN);
  assign irq_req     = irq_req_q;
  assign irq_buf     = irq_buf_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_fdma_wr_arb_mc.sv
// Directed bench for fdma_wr_arb_mc: two channels, 512-byte buffers, three-buffer rings.
module tb_fdma_wr_arb_mc;

  localparam int CH = 2;
  localparam int DW = 128;
  localparam int CW = 11;

  logic              ui_clk = 1'b0;
  logic              ui_rstn;
  logic [CH-1:0]     ch_en;
  logic [CH*CW-1:0]  ch_rcnt;
  logic [CH*DW-1:0]  ch_data;
  logic [CH-1:0]     ch_rden;
  logic              pkg_wr_areq;
  logic              pkg_wr_en;
  logic              pkg_wr_last;
  logic [31:0]       pkg_wr_addr;
  logic [DW-1:0]     pkg_wr_data;
  logic [31:0]       pkg_wr_size;
  logic [CH-1:0]     irq_req;
  logic [CH*4-1:0]   irq_buf;
  logic              busy;

  logic [CW-1:0]     rcnt [CH];
  int                fifo_ptr [CH] = '{0, 0};
  int                exp_ptr [CH] = '{0, 0};
  int                checks = 0;
  int                errors = 0;

  fdma_wr_arb_mc #(
    .ADDR_OFFSET   (32'd0),
    .CH_NUM        (CH),
    .AXI_DATA_WIDTH(DW),
    .AXI_BURST_LEN (8),
    .FDMA_BUF_SIZE (3),
    .BUF_BYTES     (512),
    .CNT_W         (CW)
  ) dut (
    .ui_clk     (ui_clk),
    .ui_rstn    (ui_rstn),
    .ch_en      (ch_en),
    .ch_rcnt    (ch_rcnt),
    .ch_data    (ch_data),
    .ch_rden    (ch_rden),
    .pkg_wr_areq(pkg_wr_areq),
    .pkg_wr_en  (pkg_wr_en),
    .pkg_wr_last(pkg_wr_last),
    .pkg_wr_addr(pkg_wr_addr),
    .pkg_wr_data(pkg_wr_data),
    .pkg_wr_size(pkg_wr_size),
    .irq_req    (irq_req),
    .irq_buf    (irq_buf),
    .busy       (busy)
  );

  always #5 ui_clk = ~ui_clk;

  assign ch_rcnt = {rcnt[1], rcnt[0]};

  // FWFT FIFO model: head word tags the channel and its pop index.
  always_comb begin
    for (int c = 0; c < CH; c++) begin
      ch_data[c*DW +: DW] = {8'(c), 88'd0, 32'(fifo_ptr[c])};
    end
  end

  always @(posedge ui_clk) begin
    for (int c = 0; c < CH; c++) begin
      if (ch_rden[c]) fifo_ptr[c] <= fifo_ptr[c] + 1;
    end
  end

  task automatic run_burst(input int ch, input logic [31:0] addr, input bit gaps,
                           input bit irq_exp, input logic [3:0] ibuf, input int drop_beat,
                           input string tag);
    int            n;
    int            beat;
    logic [CH-1:0] rd_exp;
    logic [DW-1:0] d_exp;
    logic [CH-1:0] irq_exp_v;
    n = 0;
    while (pkg_wr_areq !== 1'b1 && n < 50) begin
      @(negedge ui_clk);
      #1;
      n++;
    end
    checks++;
    if (pkg_wr_areq !== 1'b1) begin
      errors++;
      $display("FAIL %s areq: got %b, want 1 within 50 cycles", tag, pkg_wr_areq);
      return;
    end
    checks++;
    if (pkg_wr_addr !== addr) begin
      errors++;
      $display("FAIL %s addr: got %h, want %h", tag, pkg_wr_addr, addr);
    end
    beat = 0;
    n = 0;
    while (beat < 8 && n < 64) begin
      @(negedge ui_clk);
      n++;
      pkg_wr_en   = gaps ? n[0] : 1'b1;
      pkg_wr_last = pkg_wr_en && (beat == 7);
      if (beat == drop_beat) ch_en = ch_en & ~(CH'(1) << ch);
      #1;
      rd_exp = pkg_wr_en ? (CH'(1) << ch) : '0;
      checks++;
      if (ch_rden !== rd_exp) begin
        errors++;
        $display("FAIL %s rden beat %0d: got %b, want %b", tag, beat, ch_rden, rd_exp);
      end
      checks++;
      if (pkg_wr_addr !== addr || pkg_wr_areq !== 1'b0) begin
        errors++;
        $display("FAIL %s hold: addr %h areq %b, want addr %h areq 0", tag, pkg_wr_addr,
                 pkg_wr_areq, addr);
      end
      if (pkg_wr_en) begin
        d_exp = {8'(ch), 88'd0, 32'(exp_ptr[ch])};
        checks++;
        if (pkg_wr_data !== d_exp) begin
          errors++;
          $display("FAIL %s data beat %0d: got %h, want %h", tag, beat, pkg_wr_data, d_exp);
        end
        exp_ptr[ch]++;
        beat++;
      end
    end
    checks++;
    if (beat != 8) begin
      errors++;
      $display("FAIL %s beats: got %0d, want 8", tag, beat);
    end
    @(negedge ui_clk);
    pkg_wr_en   = 1'b0;
    pkg_wr_last = 1'b0;
    #1;
    irq_exp_v = irq_exp ? (CH'(1) << ch) : '0;
    checks++;
    if (irq_req !== irq_exp_v || pkg_wr_areq !== 1'b0) begin
      errors++;
      $display("FAIL %s irq: got irq %b areq %b, want irq %b areq 0", tag, irq_req,
               pkg_wr_areq, irq_exp_v);
    end
    if (irq_exp) begin
      checks++;
      if (irq_buf[ch*4 +: 4] !== ibuf) begin
        errors++;
        $display("FAIL %s irq_buf: got %0d, want %0d", tag, irq_buf[ch*4 +: 4], ibuf);
      end
    end
  endtask

  task automatic test_reset();
    ui_rstn     = 1'b0;
    ch_en       = '0;
    rcnt[0]     = '0;
    rcnt[1]     = '0;
    pkg_wr_en   = 1'b0;
    pkg_wr_last = 1'b0;
    repeat (3) @(negedge ui_clk);
    #1;
    checks++;
    if ({pkg_wr_areq, ch_rden, irq_req, irq_buf, pkg_wr_addr, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: areq %b rden %b irq %b buf %h addr %h busy %b, want all 0",
               pkg_wr_areq, ch_rden, irq_req, irq_buf, pkg_wr_addr, busy);
    end
    checks++;
    if (pkg_wr_size !== 32'd8) begin
      errors++;
      $display("FAIL reset_size: got %0d, want 8", pkg_wr_size);
    end
    @(negedge ui_clk);
    ui_rstn = 1'b1;
    repeat (3) @(negedge ui_clk);
    #1;
    checks++;
    if (busy !== 1'b1 || pkg_wr_areq !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy %b areq %b, want busy 1 areq 0", busy, pkg_wr_areq);
    end
  endtask

  task automatic test_single_channel();
    logic [31:0] a [5] = '{32'h000, 32'h080, 32'h100, 32'h180, 32'h200};
    bit          q [5] = '{0, 0, 0, 1, 0};
    rcnt[0] = 11'd8;
    ch_en   = 2'b01;
    for (int i = 0; i < 5; i++) run_burst(0, a[i], 1'b0, q[i], 4'd0, -1, "single");
  endtask

  task automatic test_threshold();
    int hits;
    int n;
    rcnt[0] = 11'd7;
    hits = 0;
    repeat (100) begin
      @(negedge ui_clk);
      #1;
      if (pkg_wr_areq) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL threshold_idle: got %0d requests, want 0", hits);
    end
    rcnt[0] = 11'd8;
    n = 0;
    while (pkg_wr_areq !== 1'b1 && n < 2) begin
      @(negedge ui_clk);
      #1;
      n++;
    end
    checks++;
    if (pkg_wr_areq !== 1'b1) begin
      errors++;
      $display("FAIL threshold_latency: areq %b after %0d cycles, want 1 within 2", pkg_wr_areq, n);
    end
    run_burst(0, 32'h280, 1'b0, 1'b0, 4'd0, -1, "threshold");
  endtask

  task automatic test_ring_wrap();
    logic [31:0] a [11] = '{32'h300, 32'h380, 32'h400, 32'h480, 32'h500, 32'h580,
                            32'h000, 32'h080, 32'h100, 32'h180, 32'h200};
    bit          q [11] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    logic [3:0]  b [11] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 11; i++) run_burst(0, a[i], 1'b0, q[i], b[i], -1, "ring");
  endtask

  task automatic test_back_pressure();
    run_burst(0, 32'h280, 1'b1, 1'b0, 4'd0, -1, "bp0");
    run_burst(0, 32'h300, 1'b1, 1'b0, 4'd0, -1, "bp1");
  endtask

  task automatic test_fairness();
    rcnt[0] = 11'd64;
    rcnt[1] = 11'd64;
    ch_en   = 2'b11;
    run_burst(1, 32'h600, 1'b0, 1'b0, 4'd0, -1, "fair_a");
    run_burst(0, 32'h380, 1'b0, 1'b1, 4'd1, -1, "fair_b");
    run_burst(1, 32'h680, 1'b0, 1'b0, 4'd0, -1, "fair_c");
    run_burst(0, 32'h400, 1'b0, 1'b0, 4'd0, -1, "fair_d");
  endtask

  task automatic test_disable();
    int hits;
    rcnt[0] = 11'd8;
    ch_en   = 2'b01;
    run_burst(0, 32'h480, 1'b0, 1'b0, 4'd0, 3, "disable");
    hits = 0;
    repeat (10) begin
      @(negedge ui_clk);
      #1;
      if (pkg_wr_areq || irq_req != '0) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL disable_quiet: got %0d active cycles, want 0", hits);
    end
    ch_en = 2'b01;
    run_burst(0, 32'h000, 1'b0, 1'b0, 4'd0, -1, "reenable");
  endtask

  task automatic test_reset_mid_burst();
    int n;
    int hits;
    n = 0;
    while (pkg_wr_areq !== 1'b1 && n < 50) begin
      @(negedge ui_clk);
      #1;
      n++;
    end
    checks++;
    if (pkg_wr_areq !== 1'b1 || pkg_wr_addr !== 32'h080) begin
      errors++;
      $display("FAIL rst_mid_req: areq %b addr %h, want 1 and 080", pkg_wr_areq, pkg_wr_addr);
    end
    repeat (3) begin
      @(negedge ui_clk);
      pkg_wr_en = 1'b1;
      #1;
      if (ch_rden[0]) exp_ptr[0]++;
    end
    @(negedge ui_clk);
    ui_rstn = 1'b0;
    #1;
    checks++;
    if (pkg_wr_areq !== 1'b0 || ch_rden !== '0 || busy !== 1'b0 || pkg_wr_addr !== '0) begin
      errors++;
      $display("FAIL rst_mid_clear: areq %b rden %b busy %b addr %h, want all 0",
               pkg_wr_areq, ch_rden, busy, pkg_wr_addr);
    end
    pkg_wr_en = 1'b0;
    ch_en     = '0;
    repeat (2) @(negedge ui_clk);
    ui_rstn = 1'b1;
    hits = 0;
    repeat (6) begin
      @(negedge ui_clk);
      #1;
      if (irq_req != '0 || pkg_wr_areq) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL rst_mid_irq: got %0d active cycles, want 0", hits);
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_threshold();
    test_ring_wrap();
    test_back_pressure();
    test_fairness();
    test_disable();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
